// File: rtl/data_memory_ctrl.sv
// Byte-organised, big-endian data memory with a fixed-latency request/response
// handshake. Stores commit and loads sample the array on the accept edge; the
// response is presented READ_LATENCY cycles later as a one-cycle strobe.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend (1) or sign-extend (0) sub-word loads
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle response strobe
//   rsp_rdata         load result, held until the next load response
//   rsp_error         request faulted, qualified by rsp_valid
//   db_data_source    data_bus select: 0 accepted address, 1 rsp_rdata
//   data_bus          write-back bus
module data_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        db_data_source,
  output logic [31:0] data_bus
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [1:0]  CntInit = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            mem [Depth];
  logic                  accept, req_err, enter_resp;
  logic [ADDR_WIDTH-1:0] idx;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_word, ld_data;
  logic                  write_q, err_q, rsp_error_q;
  logic [31:0]           ldata_q, addr_q, rsp_rdata_q;
  logic                  src_write, src_err;
  logic [31:0]           src_ldata;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign idx       = req_addr[ADDR_WIDTH-1:0];

  // Aligned accesses never cross the top of the array, so range checking only
  // needs the bits above the array index.
  always_comb begin
    req_err = |req_addr[31:ADDR_WIDTH];
    case (req_size)
      2'b00:   req_err = req_err;
      2'b01:   req_err = req_err | req_addr[0];
      2'b10:   req_err = req_err | (|req_addr[1:0]);
      default: req_err = 1'b1;
    endcase
  end

  // Big-endian: the lowest address carries the most significant byte.
  assign ld_byte = mem[idx];
  assign ld_half = {mem[{idx[ADDR_WIDTH-1:1], 1'b0}], mem[{idx[ADDR_WIDTH-1:1], 1'b1}]};
  assign ld_word = {mem[{idx[ADDR_WIDTH-1:2], 2'd0}], mem[{idx[ADDR_WIDTH-1:2], 2'd1}],
                    mem[{idx[ADDR_WIDTH-1:2], 2'd2}], mem[{idx[ADDR_WIDTH-1:2], 2'd3}]};

  always_comb begin
    ld_data = 32'd0;
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = req_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      2'b10:   ld_data = ld_word;
      default: ld_data = 32'd0;
    endcase
    if (req_err) ld_data = 32'd0;
  end

  // The array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      case (req_size)
        2'b00: mem[idx] <= req_wdata[7:0];
        2'b01: begin
          mem[{idx[ADDR_WIDTH-1:1], 1'b0}] <= req_wdata[15:8];
          mem[{idx[ADDR_WIDTH-1:1], 1'b1}] <= req_wdata[7:0];
        end
        2'b10: begin
          mem[{idx[ADDR_WIDTH-1:2], 2'd0}] <= req_wdata[31:24];
          mem[{idx[ADDR_WIDTH-1:2], 2'd1}] <= req_wdata[23:16];
          mem[{idx[ADDR_WIDTH-1:2], 2'd2}] <= req_wdata[15:8];
          mem[{idx[ADDR_WIDTH-1:2], 2'd3}] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // The counter reaches 0 on the edge that enters RESP, which places the
  // response strobe in the READ_LATENCY-th cycle after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (READ_LATENCY <= 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // With single-cycle latency RESP is entered on the accept edge itself, so the
  // response must come straight from the request rather than the captured copy.
  assign src_write = accept ? req_write : write_q;
  assign src_err   = accept ? req_err   : err_q;
  assign src_ldata = accept ? ld_data   : ldata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      ldata_q     <= 32'd0;
      addr_q      <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        ldata_q <= ld_data;
        addr_q  <= req_addr;
      end
      if (enter_resp) begin
        rsp_error_q <= src_err;
        if (!src_write) rsp_rdata_q <= src_ldata;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_error = rsp_valid & rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign data_bus  = db_data_source ? rsp_rdata_q : addr_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 256;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        db_data_source;
  logic [31:0] data_bus;

  data_memory_ctrl #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .db_data_source(db_data_source),
    .data_bus      (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] hold_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte array, big-endian assembly with plain arithmetic.
  task automatic model(input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_rd);
    longint nb, addr;
    longint val;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    addr = {32'd0, a};
    e_err = (sz == 2'd3) || (addr % nb != 0) || (addr + nb > DEPTH);
    if (!w) begin
      val = 0;
      if (!e_err) begin
        for (longint i = 0; i < nb; i++) val = val * 256 + longint'(ref_mem[addr + i]);
        if (!un && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
          val = val + 64'h1_0000_0000 - (longint'(1) << (8 * nb));
      end
      hold_rdata = val[31:0];
    end else if (!e_err) begin
      for (longint i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wd >> (8 * (nb - 1 - i)));
    end
    e_rd = hold_rdata;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write    = w;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic        e_err;
    logic [31:0] e_rd;
    int          n;
    model(w, sz, un, a, wd, e_err, e_rd);
    @(negedge clk);
    drive(w, sz, un, a, wd);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, e_err});
    chk("rsp_rdata", rsp_rdata, e_rd);
    rd = rsp_rdata;
    er = rsp_error;
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        e_err;
    logic [31:0] e_rd;
    int          n;
    int          seen;

    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; db_data_source = 1'b0;
    hold_rdata = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_data_bus_addr", data_bus, 32'd0);
    db_data_source = 1'b1;
    #1 chk("reset_data_bus_rdata", data_bus, 32'd0);
    db_data_source = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Fill the whole array so later loads never depend on power-up content.
    for (int i = 0; i < DEPTH / 4; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, er);

    // Word store, sub-word loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, rd, er);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, er);
    chk("byte_load_0x11", rd, 32'h0000_0022);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, er);
    chk("half_load_0x12", rd, 32'h0000_3344);

    // Sign extension.
    do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_0080, rd, er);
    do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, rd, er);
    chk("byte_signed", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'd0, rd, er);
    chk("byte_unsigned", rd, 32'h0000_0080);

    // Faults.
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, rd, er);
    chk("misaligned_word_err", {31'd0, er}, 32'd1);
    chk("misaligned_word_rdata", rd, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h08, 32'd0, rd, er);
    chk("size11_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, er);
    chk("oob_store_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, rd, er);
    do_req(1'b0, 2'd2, 1'b0, 32'hFC, 32'd0, rd, er);
    chk("last_word_ok", {31'd0, er}, 32'd0);

    // req_valid held high: ready low for the whole latency, next accept at cycle 4.
    model(1'b0, 2'd2, 1'b1, 32'h10, 32'd0, e_err, e_rd);
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b1, 32'h10, 32'd0);
    chk("held_ready0", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("held_ready_low", {31'd0, req_ready}, 32'd0);
      chk("held_rsp_valid", {31'd0, rsp_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("held_rdata", rsp_rdata, e_rd);
    end
    @(negedge clk);
    chk("held_ready_cycle4", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("held_second_accept", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("held_drain", {31'd0, req_ready}, 32'd1);

    // Reset one cycle after a store accept: response dropped, store kept.
    model(1'b1, 2'd2, 1'b0, 32'h40, 32'hAABB_CCDD, e_err, e_rd);
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hAABB_CCDD);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("async_reset_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rdata = 32'd0;
    #1 chk("reset_ready_again", {31'd0, req_ready}, 32'd1);
    chk("reset_rdata_cleared", rsp_rdata, 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("dropped_response", seen, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd, er);
    chk("store_survives_reset", rd, 32'hAABB_CCDD);

    // data_bus source select.
    do_req(1'b0, 2'd2, 1'b0, 32'h44, 32'd0, rd, er);
    for (int k = 0; k < 4; k++) begin
      db_data_source = k[0];
      #1 chk("data_bus", data_bus, k[0] ? hold_rdata : 32'h0000_0044);
    end
    db_data_source = 1'b0;

    // Randomised traffic, including faults and out-of-range addresses.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 260));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
